// File: rtl/serial_msg_parser.sv
`default_nettype none
// ============================================================================
// Module   : serial_msg_parser
// Purpose  : Hunts NUM_TYPES header sequences in a UART byte stream, tags the
//            frame with its type id and forwards PAYLOAD_LEN[type] bytes, with
//            optional inter-byte timeout and optional trailing XOR checksum
//            (enabled by defining MSG_CHECKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module serial_msg_parser #(
    parameter int                              NUM_TYPES      = 2,
    parameter int                              HDR_LEN        = 5,
    parameter logic [NUM_TYPES*HDR_LEN*8-1:0]  HEADERS        = {"FGHIJ", "ABCDE"},
    parameter logic [NUM_TYPES*16-1:0]         PAYLOAD_LENS   = {16'd16, 16'd8},
    parameter int                              TIMEOUT_CYCLES = 0,
    localparam int                             TYPE_W         = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    output logic [7:0]        msg_out,
    output logic              data_valid,
    output logic [TYPE_W-1:0] msg_type,
    output logic              msg_active,
    output logic              msg_start,
    output logic              msg_done,
    output logic              frame_err
);

    localparam int IDX_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef MSG_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_ZLEN    = 3'd3,
        S_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_ZLEN    = 3'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [NUM_TYPES-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]    hdr_idx_q, hdr_idx_d;
    logic [15:0]         countdown_q, countdown_d;
    logic [TO_W-1:0]     gap_q, gap_d;
    logic [7:0]          msg_out_q, msg_out_d;
    logic                data_valid_q, data_valid_d;
    logic [TYPE_W-1:0]   msg_type_q, msg_type_d;
    logic                msg_active_q, msg_active_d;
    logic                msg_start_q, msg_start_d;
    logic                msg_done_q, msg_done_d;
    logic                frame_err_q, frame_err_d;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]          acc_q, acc_d;
`endif

    logic [7:0]           w_hdr_byte [NUM_TYPES][HDR_LEN];
    logic [NUM_TYPES-1:0] w_match_first;
    logic [NUM_TYPES-1:0] w_match_idx;
    logic [NUM_TYPES-1:0] w_cand;
    logic                 w_complete;
    logic [IDX_W-1:0]     w_next_idx;
    logic [TYPE_W-1:0]    w_sel;
    logic [15:0]          w_sel_len;
    logic                 w_in_frame;
    logic                 w_timeout;

    // Header table: byte 0 of each type is the most-significant byte of its slice.
    generate
        for (genvar k = 0; k < NUM_TYPES; k++) begin : g_type
            for (genvar i = 0; i < HDR_LEN; i++) begin : g_byte
                assign w_hdr_byte[k][i] = HEADERS[(k*HDR_LEN + HDR_LEN - 1 - i)*8 +: 8];
            end
            assign w_match_first[k] = (rx_data == w_hdr_byte[k][0]);
            assign w_match_idx[k]   = (rx_data == w_hdr_byte[k][hdr_idx_q]);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        hdr_idx_d    = hdr_idx_q;
        countdown_d  = countdown_q;
        gap_d        = '0;
        msg_out_d    = msg_out_q;
        data_valid_d = 1'b0;
        msg_type_d   = msg_type_q;
        msg_active_d = msg_active_q;
        msg_start_d  = 1'b0;
        msg_done_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef MSG_CHECKSUM_EN
        acc_d        = acc_q;
`endif
        w_sel        = '0;
        w_sel_len    = '0;
        w_next_idx   = IDX_W'(1);

        // Surviving candidates continue; otherwise the same byte restarts the hunt.
        if (state_q == S_HDR && (mask_q & w_match_idx) != '0) begin
            w_cand     = mask_q & w_match_idx;
            w_complete = (hdr_idx_q == IDX_LAST);
            w_next_idx = hdr_idx_q + IDX_W'(1);
        end else begin
            w_cand     = w_match_first;
            w_complete = (HDR_LEN == 1);
        end

        for (int k = NUM_TYPES - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_sel     = TYPE_W'(k);
                w_sel_len = PAYLOAD_LENS[k*16 +: 16];
            end
        end

        w_in_frame = (state_q != S_HUNT) && (state_q != S_ZLEN);
        w_timeout  = (TIMEOUT_CYCLES > 0) && w_in_frame && !rx_data_ready && (gap_q == TO_LAST);
        if ((TIMEOUT_CYCLES > 0) && w_in_frame && !rx_data_ready && !w_timeout) begin
            gap_d = gap_q + TO_W'(1);
        end

        case (state_q)
            S_HUNT, S_ZLEN, S_HDR: begin
                if (state_q == S_ZLEN) begin
                    msg_done_d   = 1'b1;
                    msg_active_d = 1'b0;
                    state_d      = S_HUNT;
                end
                if (rx_data_ready) begin
                    if (w_cand == '0) begin
                        state_d   = S_HUNT;
                        mask_d    = '0;
                        hdr_idx_d = '0;
                    end else if (w_complete) begin
                        state_d      = (w_sel_len == 16'd0) ? S_ZLEN : S_PAYLOAD;
                        mask_d       = '0;
                        hdr_idx_d    = '0;
                        msg_type_d   = w_sel;
                        msg_start_d  = 1'b1;
                        msg_active_d = 1'b1;
                        countdown_d  = w_sel_len;
`ifdef MSG_CHECKSUM_EN
                        acc_d        = 8'h00;
`endif
                    end else begin
                        state_d   = S_HDR;
                        mask_d    = w_cand;
                        hdr_idx_d = w_next_idx;
                    end
                end else if (w_timeout) begin
                    // Header timeouts abandon the partial match without signalling.
                    state_d   = S_HUNT;
                    mask_d    = '0;
                    hdr_idx_d = '0;
                end
            end
            S_PAYLOAD: begin
                if (rx_data_ready) begin
                    msg_out_d    = rx_data;
                    data_valid_d = 1'b1;
                    countdown_d  = countdown_q - 16'd1;
`ifdef MSG_CHECKSUM_EN
                    acc_d        = acc_q ^ rx_data;
                    if (countdown_q == 16'd1) begin
                        state_d = S_CHECK;
                    end
`else
                    if (countdown_q == 16'd1) begin
                        msg_done_d   = 1'b1;
                        msg_active_d = 1'b0;
                        state_d      = S_HUNT;
                    end
`endif
                end else if (w_timeout) begin
                    frame_err_d  = 1'b1;
                    msg_active_d = 1'b0;
                    state_d      = S_HUNT;
                end
            end
`ifdef MSG_CHECKSUM_EN
            S_CHECK: begin
                if (rx_data_ready) begin
                    if (rx_data == acc_q) begin
                        msg_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    msg_active_d = 1'b0;
                    state_d      = S_HUNT;
                end else if (w_timeout) begin
                    frame_err_d  = 1'b1;
                    msg_active_d = 1'b0;
                    state_d      = S_HUNT;
                end
            end
`endif
            default: begin
                state_d   = S_HUNT;
                mask_d    = '0;
                hdr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HUNT;
            mask_q       <= '0;
            hdr_idx_q    <= '0;
            countdown_q  <= '0;
            gap_q        <= '0;
            msg_out_q    <= '0;
            data_valid_q <= 1'b0;
            msg_type_q   <= '0;
            msg_active_q <= 1'b0;
            msg_start_q  <= 1'b0;
            msg_done_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef MSG_CHECKSUM_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            hdr_idx_q    <= hdr_idx_d;
            countdown_q  <= countdown_d;
            gap_q        <= gap_d;
            msg_out_q    <= msg_out_d;
            data_valid_q <= data_valid_d;
            msg_type_q   <= msg_type_d;
            msg_active_q <= msg_active_d;
            msg_start_q  <= msg_start_d;
            msg_done_q   <= msg_done_d;
            frame_err_q  <= frame_err_d;
`ifdef MSG_CHECKSUM_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign msg_out    = msg_out_q;
    assign data_valid = data_valid_q;
    assign msg_type   = msg_type_q;
    assign msg_active = msg_active_q;
    assign msg_start  = msg_start_q;
    assign msg_done   = msg_done_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_msg_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_msg_parser
// Purpose  : Self-checking bench for serial_msg_parser (default headers,
//            TIMEOUT_CYCLES=100); adapts to MSG_CHECKSUM_EN builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_msg_parser;

    localparam int TYPE_W  = 1;
    localparam int TO      = 100;
    localparam int K_START = 0;
    localparam int K_DATA  = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } evt_t;

    typedef struct {
        logic [63:0] pre;
        int          pre_n;
        int          typ;
        logic [7:0]  base;
        int          exp_type;
        int          exp_len;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_data_ready = 1'b0;
    logic [7:0]        msg_out;
    logic              data_valid;
    logic [TYPE_W-1:0] msg_type;
    logic              msg_active;
    logic              msg_start;
    logic              msg_done;
    logic              frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    evt_t       sb[$];
    logic [7:0] cur_type = 8'h00;
    logic [39:0] hdr_str [2];
    vec_t       vec [6];

    serial_msg_parser #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .msg_out      (msg_out),
        .data_valid   (data_valid),
        .msg_type     (msg_type),
        .msg_active   (msg_active),
        .msg_start    (msg_start),
        .msg_done     (msg_done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_evt(input int kind, input logic [7:0] val);
        evt_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d val=%02h required none at %0t", kind, val, $time);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL event_order: got kind=%0d val=%02h required kind=%0d val=%02h at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_start) begin
                expect_evt(K_START, 8'(msg_type));
                check("active_at_start", 32'(msg_active), 32'd1);
            end
            if (data_valid) begin
                expect_evt(K_DATA, msg_out);
                check("type_stable", 32'(msg_type), 32'(cur_type));
            end
            if (msg_done)  expect_evt(K_DONE, 8'h00);
            if (frame_err) expect_evt(K_ERR, 8'h00);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_header(input int typ, input int exp_type);
        logic [39:0] h;
        h = hdr_str[typ];
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                push(K_START, 8'(exp_type));
                cur_type = 8'(exp_type);
            end
            send_byte(h[(4-i)*8 +: 8], 0);
        end
    endtask

    task automatic send_frame(input int typ, input int n, input logic [7:0] base, input int exp_type);
        logic [7:0] b;
        logic [7:0] acc;
        acc = 8'h00;
        send_header(typ, exp_type);
        for (int i = 0; i < n; i++) begin
            b   = base + 8'(i);
            acc = acc ^ b;
            push(K_DATA, b);
`ifndef MSG_CHECKSUM_EN
            if (i == n - 1) push(K_DONE, 8'h00);
`endif
            send_byte(b, 0);
        end
`ifdef MSG_CHECKSUM_EN
        push(K_DONE, 8'h00);
        send_byte(acc, 0);
`endif
    endtask

    task automatic settle_and_check(input string tag);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_active_low"}, 32'(msg_active), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        hdr_str[0] = "ABCDE";
        hdr_str[1] = "FGHIJ";
        //        prefix      n  typ base    exp_type exp_len
        vec[0] = '{64'h0,     0, 0, 8'h01, 0,  8};
        vec[1] = '{"ABCDX",   5, 1, 8'h10, 1, 16};
        vec[2] = '{"A",       1, 0, 8'hA0, 0,  8};
        vec[3] = '{"FGHA",    4, 0, 8'h30, 0,  8};
        vec[4] = '{"ABCD",    4, 1, 8'h41, 1, 16};
        vec[5] = '{64'h0,     0, 0, 8'h41, 0,  8};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_msg_out",    32'(msg_out),    32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_msg_type",   32'(msg_type),   32'd0);
        check("rst_msg_active", 32'(msg_active), 32'd0);
        check("rst_msg_start",  32'(msg_start),  32'd0);
        check("rst_msg_done",   32'(msg_done),   32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames, back-to-back with their prefixes
        for (int v = 0; v < 6; v++) begin
            p = vec[v].pre;
            for (int i = 0; i < vec[v].pre_n; i++) begin
                send_byte(p[(vec[v].pre_n-1-i)*8 +: 8], 0);
            end
            send_frame(vec[v].typ, vec[v].exp_len, vec[v].base, vec[v].exp_type);
            settle_and_check($sformatf("vec%0d", v));
        end

        // Payload timeout: a 99-cycle gap is tolerated, a 100-cycle gap aborts
        send_header(0, 0);
        for (int i = 0; i < 3; i++) begin
            push(K_DATA, 8'(i + 1));
            send_byte(8'(i + 1), (i == 2) ? TO - 1 : 0);
        end
        push(K_DATA, 8'h04);
        push(K_ERR, 8'h00);
        send_byte(8'h04, 0);
        repeat (TO - 1) begin
            @(posedge clk); #1;
        end
        check("timeout_not_early", 32'(sb.size()), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("timeout_fired", 32'(sb.size()), 32'd0);
        check("timeout_active_low", 32'(msg_active), 32'd0);

        // Header timeout is silent; the tail of the header must not match afterwards
        send_byte("A", 0);
        send_byte("B", 0);
        send_byte("C", TO);
        send_byte("D", 0);
        send_byte("E", 0);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 0);
        settle_and_check("hdr_timeout");

        // Reset mid-frame
        send_header(0, 0);
        for (int i = 0; i < 4; i++) begin
            push(K_DATA, 8'(i + 1));
            send_byte(8'(i + 1), 0);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("pre_reset_active", 32'(msg_active), 32'd1);
        check("pre_reset_msg_out", 32'(msg_out), 32'h04);
        rst_n = 1'b0;
        #1;
        check("async_rst_msg_out", 32'(msg_out), 32'd0);
        check("async_rst_active",  32'(msg_active), 32'd0);
        check("async_rst_type",    32'(msg_type), 32'd0);
        check("async_rst_sb",      32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(0, 8, 8'h01, 0);
        settle_and_check("after_reset");

`ifdef MSG_CHECKSUM_EN
        // Explicit checksum byte: 01^02^...^08 = 08
        send_header(0, 0);
        for (int i = 0; i < 8; i++) begin
            push(K_DATA, 8'(i + 1));
            send_byte(8'(i + 1), 0);
        end
        push(K_DONE, 8'h00);
        send_byte(8'h08, 0);
        settle_and_check("cksum_good");

        send_header(0, 0);
        for (int i = 0; i < 8; i++) begin
            push(K_DATA, 8'(i + 1));
            send_byte(8'(i + 1), 0);
        end
        push(K_ERR, 8'h00);
        send_byte(8'h00, 0);
        settle_and_check("cksum_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
